// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive FIFO: entry layout,
// trigger levels, default sizing and the entry error helper.
package uart_rx_pkg;

    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_TIMEOUT_BITS = 40;

    localparam int TRIG_1  = 1;
    localparam int TRIG_4  = 4;
    localparam int TRIG_8  = 8;
    localparam int TRIG_14 = 14;

    // Packed so that the 11-bit image is {bi, fe, pe, data}
    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } entry_t;

    function automatic logic entry_has_err(input entry_t e);
        return e.pe | e.fe | e.bi;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO push bus: load strobe plus the character and its status.
interface uart_rx_fifo_if;

    logic       receive_load_en;
    logic [7:0] rsr_data;
    logic       parity_error;
    logic       frame_error;
    logic       uart_break;

    modport master (
        output receive_load_en,
        output rsr_data,
        output parity_error,
        output frame_error,
        output uart_break
    );

    modport slave (
        input receive_load_en,
        input rsr_data,
        input parity_error,
        input frame_error,
        input uart_break
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Receive entry storage: one synchronous write port, asynchronous read,
// no reset on the array (validity is tracked by the FIFO count).
module uart_rx_fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem_q [DEPTH];

    // Array write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with per-entry line status, overrun, trigger level and
// optional character timeout (enabled by defining UART_RX_TIMEOUT_EN).
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   utrrst,
    input  logic                   rx_fifo_clr,
    input  logic                   fifo_en,
    input  logic [1:0]             rx_trig,
    uart_rx_fifo_if.slave          rx_if,
    input  logic                   sample_edge,
    input  logic                   rbr_rd,
    input  logic                   lsr_rd,
    output logic [7:0]             rbr_data,
    output logic                   head_pe,
    output logic                   head_fe,
    output logic                   head_bi,
    output logic                   data_ready,
    output logic                   overrun_error,
    output logic                   rx_fifo_error,
    output logic                   rx_trig_hit,
    output logic                   rx_timeout,
    output logic [$clog2(DEPTH):0] rx_fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CAP_FIFO = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          overrun_q, overrun_d;
    logic          fifo_en_q, fifo_en_d;

    logic [CW-1:0] cap_s;
    logic          empty_s, full_s, clr_s, pop_s, push_s, ovr_set_s, wr_en_s;
    logic          push_err_s, pop_err_s;
    int            trig_lvl_s;
    entry_t        in_entry_s, head_s;

    // A change of fifo_en is seen as a clear in the cycle it happens
    assign cap_s      = fifo_en ? CAP_FIFO : CNT_ONE;
    assign empty_s    = (count_q == CNT_ZERO);
    assign full_s     = (count_q == cap_s);
    assign clr_s      = rx_fifo_clr | utrrst | (fifo_en ^ fifo_en_q);
    assign pop_s      = rbr_rd & ~empty_s;
    assign push_s     = rx_if.receive_load_en & (~full_s | pop_s);
    assign ovr_set_s  = rx_if.receive_load_en & full_s & ~pop_s;
    assign wr_en_s    = push_s & ~clr_s;
    assign push_err_s = push_s & entry_has_err(in_entry_s);
    assign pop_err_s  = pop_s & entry_has_err(head_s);

    // Pack the incoming character with its status bits
    always_comb begin
        in_entry_s      = '0;
        in_entry_s.data = rx_if.rsr_data;
        in_entry_s.pe   = rx_if.parity_error;
        in_entry_s.fe   = rx_if.frame_error;
        in_entry_s.bi   = rx_if.uart_break;
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (pclk),
        .we    (wr_en_s),
        .waddr (wr_ptr_q),
        .wdata (in_entry_s),
        .raddr (rd_ptr_q),
        .rdata (head_s)
    );

    // Pointer, count, error-count and overrun next state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        overrun_d = overrun_q;
        fifo_en_d = fifo_en;

        if (utrrst) begin
            overrun_d = 1'b0;
        end else if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (lsr_rd) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (clr_s) begin
            wr_ptr_d  = PTR_ZERO;
            rd_ptr_d  = PTR_ZERO;
            count_d   = CNT_ZERO;
            err_cnt_d = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            case ({push_err_s, pop_err_s})
                2'b10:   err_cnt_d = err_cnt_q + CNT_ONE;
                2'b01:   err_cnt_d = err_cnt_q - CNT_ONE;
                default: err_cnt_d = err_cnt_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr_q  <= PTR_ZERO;
            rd_ptr_q  <= PTR_ZERO;
            count_q   <= CNT_ZERO;
            err_cnt_q <= CNT_ZERO;
            overrun_q <= 1'b0;
            fifo_en_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            overrun_q <= overrun_d;
            fifo_en_q <= fifo_en_d;
        end
    end

    // Trigger level; holding-register mode always triggers at one entry
    always_comb begin
        trig_lvl_s = TRIG_1;
        case (rx_trig)
            2'b00:   trig_lvl_s = TRIG_1;
            2'b01:   trig_lvl_s = TRIG_4;
            2'b10:   trig_lvl_s = TRIG_8;
            2'b11:   trig_lvl_s = TRIG_14;
            default: trig_lvl_s = TRIG_1;
        endcase
        if (!fifo_en) begin
            trig_lvl_s = TRIG_1;
        end else begin
            trig_lvl_s = trig_lvl_s;
        end
    end

    // Fall-through head view, forced to zero when empty
    always_comb begin
        rbr_data = 8'h00;
        head_pe  = 1'b0;
        head_fe  = 1'b0;
        head_bi  = 1'b0;
        if (empty_s) begin
            rbr_data = 8'h00;
            head_pe  = 1'b0;
            head_fe  = 1'b0;
            head_bi  = 1'b0;
        end else begin
            rbr_data = head_s.data;
            head_pe  = head_s.pe;
            head_fe  = head_s.fe;
            head_bi  = head_s.bi;
        end
    end

    assign data_ready    = ~empty_s;
    assign overrun_error = overrun_q;
    assign rx_fifo_error = (err_cnt_q != CNT_ZERO);
    assign rx_trig_hit   = (int'(count_q) >= trig_lvl_s);
    assign rx_fifo_count = count_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [TW-1:0] TO_ZERO  = TW'(0);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_BITS);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_flag_q, to_flag_d;

    // Idle bit-time counter; saturates once the timeout is flagged
    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        if (clr_s | pop_s) begin
            to_cnt_d  = TO_ZERO;
            to_flag_d = 1'b0;
        end else if (push_s | empty_s) begin
            to_cnt_d  = TO_ZERO;
            to_flag_d = to_flag_q;
        end else if (sample_edge & (to_cnt_q != TO_LIMIT)) begin
            to_cnt_d  = to_cnt_q + TO_ONE;
            to_flag_d = to_flag_q | ((to_cnt_q + TO_ONE) == TO_LIMIT);
        end else begin
            to_cnt_d  = to_cnt_q;
            to_flag_d = to_flag_q;
        end
    end

    // Timeout registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            to_cnt_q  <= TO_ZERO;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign rx_timeout = to_flag_q;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = sample_edge ^ (TIMEOUT_BITS > 0);
    assign rx_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
    import uart_rx_pkg::*;

    localparam int DEPTH = 16;
    localparam int TBITS = 40;

    logic       pclk = 1'b0;
    logic       presetn, utrrst, rx_fifo_clr, fifo_en, sample_edge, rbr_rd, lsr_rd;
    logic [1:0] rx_trig;
    logic [7:0] rbr_data;
    logic       head_pe, head_fe, head_bi, data_ready, overrun_error;
    logic       rx_fifo_error, rx_trig_hit, rx_timeout;
    logic [4:0] rx_fifo_count;

    uart_rx_fifo_if rx_if ();

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_BITS(TBITS)) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .utrrst        (utrrst),
        .rx_fifo_clr   (rx_fifo_clr),
        .fifo_en       (fifo_en),
        .rx_trig       (rx_trig),
        .rx_if         (rx_if.slave),
        .sample_edge   (sample_edge),
        .rbr_rd        (rbr_rd),
        .lsr_rd        (lsr_rd),
        .rbr_data      (rbr_data),
        .head_pe       (head_pe),
        .head_fe       (head_fe),
        .head_bi       (head_bi),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .rx_fifo_error (rx_fifo_error),
        .rx_trig_hit   (rx_trig_hit),
        .rx_timeout    (rx_timeout),
        .rx_fifo_count (rx_fifo_count)
    );

    always #5 pclk = ~pclk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: the stored characters as a queue of {bi,fe,pe,data}
    logic [10:0] mq[$];
    bit          m_ovr, m_fen_prev, m_to_flag;
    int          m_to_cnt;

    function automatic void cmp(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovr      = 1'b0;
        m_fen_prev = 1'b0;
        m_to_flag  = 1'b0;
        m_to_cnt   = 0;
    endfunction

    // Apply the rules for one clock edge given the inputs presented to it
    function automatic void model_step();
        int cap;
        bit empty, full, pop, push, clr, ovr_set;
        logic [10:0] e;
        if (!presetn) begin
            model_reset();
            return;
        end
        cap     = fifo_en ? DEPTH : 1;
        empty   = (mq.size() == 0);
        full    = (mq.size() == cap);
        pop     = rbr_rd && !empty;
        push    = rx_if.receive_load_en && (!full || pop);
        clr     = rx_fifo_clr || utrrst || (fifo_en != m_fen_prev);
        ovr_set = rx_if.receive_load_en && full && !pop;
        e = {rx_if.uart_break, rx_if.frame_error, rx_if.parity_error, rx_if.rsr_data};

        if (utrrst) m_ovr = 1'b0;
        else if (ovr_set) m_ovr = 1'b1;
        else if (lsr_rd) m_ovr = 1'b0;

        if (clr || pop) begin
            m_to_cnt = 0;
            m_to_flag = 1'b0;
        end else if (push || empty) begin
            m_to_cnt = 0;
        end else if (sample_edge && m_to_cnt < TBITS) begin
            m_to_cnt++;
            if (m_to_cnt == TBITS) m_to_flag = 1'b1;
        end

        if (clr) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push && !clr) mq.push_back(e);
        end
        m_fen_prev = fifo_en;
    endfunction

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge pclk) begin : compare_p
        logic [10:0] h;
        int lvl;
        int err;
        h = (mq.size() > 0) ? mq[0] : 11'h000;
        err = 0;
        foreach (mq[i]) if (mq[i][10:8] != 3'b000) err = 1;
        case (rx_trig)
            2'b00:   lvl = 1;
            2'b01:   lvl = 4;
            2'b10:   lvl = 8;
            default: lvl = 14;
        endcase
        if (!fifo_en) lvl = 1;
        cmp("rbr_data", int'(rbr_data), int'(h[7:0]));
        cmp("head_pe", int'(head_pe), int'(h[8]));
        cmp("head_fe", int'(head_fe), int'(h[9]));
        cmp("head_bi", int'(head_bi), int'(h[10]));
        cmp("data_ready", int'(data_ready), (mq.size() > 0) ? 1 : 0);
        cmp("overrun", int'(overrun_error), int'(m_ovr));
        cmp("fifo_error", int'(rx_fifo_error), err);
        cmp("trig_hit", int'(rx_trig_hit), (mq.size() >= lvl) ? 1 : 0);
        cmp("count", int'(rx_fifo_count), mq.size());
`ifdef UART_RX_TIMEOUT_EN
        cmp("timeout", int'(rx_timeout), int'(m_to_flag));
`else
        cmp("timeout", int'(rx_timeout), 0);
`endif
    end

    task automatic cyc();
        @(posedge pclk);
        model_step();
        #1;
        rx_if.receive_load_en = 1'b0;
        rx_if.parity_error    = 1'b0;
        rx_if.frame_error     = 1'b0;
        rx_if.uart_break      = 1'b0;
        rbr_rd      = 1'b0;
        lsr_rd      = 1'b0;
        rx_fifo_clr = 1'b0;
        utrrst      = 1'b0;
        sample_edge = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        rx_if.rsr_data        = d;
        rx_if.parity_error    = pe;
        rx_if.receive_load_en = 1'b1;
        cyc();
    endtask

    task automatic pop();
        rbr_rd = 1'b1;
        cyc();
    endtask

    initial begin
        int lp, rp;
        presetn = 1'b0; utrrst = 1'b0; rx_fifo_clr = 1'b0; fifo_en = 1'b1;
        rx_trig = 2'b00; sample_edge = 1'b0; rbr_rd = 1'b0; lsr_rd = 1'b0;
        rx_if.receive_load_en = 1'b0; rx_if.rsr_data = 8'h00;
        rx_if.parity_error = 1'b0; rx_if.frame_error = 1'b0; rx_if.uart_break = 1'b0;
        model_reset();
        #2;
        cmp("rst_count", int'(rx_fifo_count), 0);
        cmp("rst_ready", int'(data_ready), 0);
        cmp("rst_ovr", int'(overrun_error), 0);
        cyc(); cyc();
        presetn = 1'b1;
        cyc(); cyc();

        // In-order delivery of three characters
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
        cmp("d_cnt3", int'(rx_fifo_count), 3);
        cmp("d_h41", int'(rbr_data), 8'h41);
        pop(); cmp("d_h42", int'(rbr_data), 8'h42);
        pop(); cmp("d_h43", int'(rbr_data), 8'h43);
        pop(); cmp("d_cnt0", int'(rx_fifo_count), 0);
        cmp("d_ready0", int'(data_ready), 0);

        // Overflow: 17 pushes, last one lost
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i), 1'b0);
        cmp("o_cnt16", int'(rx_fifo_count), 16);
        cmp("o_ovr1", int'(overrun_error), 1);
        lsr_rd = 1'b1; cyc();
        cmp("o_ovr_clr", int'(overrun_error), 0);
        for (int i = 0; i < 16; i++) begin
            cmp("o_order", int'(rbr_data), 8'h80 + i);
            pop();
        end
        cmp("o_empty", int'(data_ready), 0);

        // Error tracking follows the errored entry out
        push(8'h55, 1'b1); push(8'h66, 1'b0);
        cmp("e_err1", int'(rx_fifo_error), 1);
        cmp("e_pe1", int'(head_pe), 1);
        pop();
        cmp("e_err0", int'(rx_fifo_error), 0);
        cmp("e_h66", int'(rbr_data), 8'h66);
        pop();

        // Trigger at 8, then full with simultaneous push and pop
        rx_trig = 2'b10;
        for (int i = 0; i < 7; i++) push(8'(i), 1'b0);
        cmp("t_hit0", int'(rx_trig_hit), 0);
        push(8'h07, 1'b0);
        cmp("t_hit1", int'(rx_trig_hit), 1);
        for (int i = 8; i < 16; i++) push(8'(i), 1'b0);
        rx_if.rsr_data = 8'hAA; rx_if.receive_load_en = 1'b1; rbr_rd = 1'b1; cyc();
        cmp("t_cnt16", int'(rx_fifo_count), 16);
        cmp("t_ovr0", int'(overrun_error), 0);
        cmp("t_head1", int'(rbr_data), 8'h01);
        rx_fifo_clr = 1'b1; cyc();
        cmp("t_clr", int'(rx_fifo_count), 0);
        rx_trig = 2'b00;

        // Holding-register overrun survives fifo_en change; reset clears all
        fifo_en = 1'b0; cyc();
        push(8'h11, 1'b0); push(8'h12, 1'b0);
        cmp("h_ovr", int'(overrun_error), 1);
        cmp("h_head", int'(rbr_data), 8'h11);
        fifo_en = 1'b1; cyc();
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 1'b0);
        cmp("r_cnt5", int'(rx_fifo_count), 5);
        presetn = 1'b0; model_reset(); #1;
        cmp("r_cnt0", int'(rx_fifo_count), 0);
        cmp("r_ready0", int'(data_ready), 0);
        cmp("r_ovr0", int'(overrun_error), 0);
        cyc();
        presetn = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 1'b0);
        fifo_en = 1'b0; cyc();
        cmp("f_toggle", int'(rx_fifo_count), 0);
        fifo_en = 1'b1; cyc();

        // Character timeout
        push(8'h77, 1'b0);
        for (int i = 0; i < TBITS - 1; i++) begin sample_edge = 1'b1; cyc(); end
        cmp("to_39", int'(rx_timeout), 0);
        sample_edge = 1'b1; cyc();
`ifdef UART_RX_TIMEOUT_EN
        cmp("to_40", int'(rx_timeout), 1);
`else
        cmp("to_off", int'(rx_timeout), 0);
`endif
        pop();
        cmp("to_pop", int'(rx_timeout), 0);
        push(8'h78, 1'b0);
        for (int i = 0; i < TBITS - 2; i++) begin sample_edge = 1'b1; cyc(); end
        sample_edge = 1'b1; push(8'h79, 1'b0);
        sample_edge = 1'b1; cyc();
        cmp("to_restart", int'(rx_timeout), 0);
        for (int i = 0; i < TBITS - 2; i++) begin sample_edge = 1'b1; cyc(); end
        cmp("to_r39", int'(rx_timeout), 0);
        sample_edge = 1'b1; cyc();
`ifdef UART_RX_TIMEOUT_EN
        cmp("to_r40", int'(rx_timeout), 1);
`endif
        rx_fifo_clr = 1'b1; cyc();
        cmp("to_clr", int'(rx_timeout), 0);

        // Randomized phases: fill-heavy, drain-heavy, balanced, idle
        for (int ph = 0; ph < 4; ph++) begin
            lp = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 55 : 4;
            rp = (ph == 0) ? 20 : (ph == 1) ? 70 : (ph == 2) ? 50 : 2;
            for (int i = 0; i < 700; i++) begin
                rx_if.receive_load_en = ($urandom_range(99) < lp);
                rx_if.rsr_data        = 8'($urandom_range(255));
                rx_if.parity_error    = ($urandom_range(7) == 0);
                rx_if.frame_error     = ($urandom_range(9) == 0);
                rx_if.uart_break      = ($urandom_range(11) == 0);
                rbr_rd      = ($urandom_range(99) < rp);
                lsr_rd      = ($urandom_range(9) == 0);
                rx_fifo_clr = ($urandom_range(149) == 0);
                utrrst      = ($urandom_range(199) == 0);
                sample_edge = ($urandom_range(99) < 60);
                if ($urandom_range(249) == 0) fifo_en = ~fifo_en;
                if ($urandom_range(39) == 0) rx_trig = 2'($urandom_range(3));
                cyc();
            end
        end

        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of receive entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 40, number of idle sample_edge pulses before a character timeout.
REQ-003 SHALL use one clock and an asynchronous active-low reset: pclk input 1 (clock); presetn input 1 (async active-low reset).
REQ-004 SHALL have these inputs:
- utrrst, 1 bit: synchronous UART soft reset.
- rx_fifo_clr, 1 bit: synchronous FIFO clear pulse.
- fifo_en, 1 bit: 1 = FIFO mode, 0 = single holding register.
- rx_trig, 2 bits: trigger-level select.
- receive_load_en, 1 bit: push strobe from receiver.
- rsr_data, 8 bits: received character.
- parity_error, frame_error, uart_break, 1 bit each: status of that character.
- sample_edge, 1 bit: bit-time tick.
- rbr_rd, 1 bit: pop strobe from register read.
- lsr_rd, 1 bit: line-status read.
REQ-005 SHALL have these outputs:
- rbr_data, 8 bits: head character.
- head_pe, head_fe, head_bi, 1 bit each: head entry flags.
- data_ready, 1 bit: FIFO not empty.
- overrun_error, 1 bit.
- rx_fifo_error, 1 bit: any stored entry has PE, FE or BI set.
- rx_trig_hit, 1 bit.
- rx_timeout, 1 bit.
- rx_fifo_count, clog2(DEPTH)+1 bits.

Function
REQ-006 SHALL store 11-bit entries {uart_break, frame_error, parity_error, rsr_data} on a cycle with receive_load_en=1 when not full.
REQ-007 SHALL be first-word fall-through: rbr_data and head_* show the head entry combinationally; all are 0 when empty.
REQ-008 SHALL pop the head on rbr_rd=1 when not empty; rbr_rd when empty SHALL be ignored and the count stays 0.
REQ-009 SHALL report an effective capacity of DEPTH when fifo_en=1 and 1 when fifo_en=0.
REQ-010 SHALL, on simultaneous push and pop, perform both with the count unchanged, including when full.
REQ-011 SHALL, on a push when full with no pop, discard the new character, leave contents unchanged, and set overrun_error the next cycle.
REQ-012 SHALL clear overrun_error on lsr_rd; if set and clear coincide, set SHALL win.
REQ-013 SHALL wrap read and write pointers modulo DEPTH with a separate count register; full when count equals capacity.
REQ-014 SHALL track stored error entries with a counter (+1 on push of an errored entry, -1 on pop of one); rx_fifo_error=1 iff the counter is nonzero.
REQ-015 SHALL assert rx_trig_hit while count >= trigger level, where rx_trig 00/01/10/11 selects 1/4/8/14; when fifo_en=0 the trigger level SHALL be 1.
REQ-016 SHALL clear the FIFO (pointers, count, error counter) on rx_fifo_clr, utrrst, or any change of fifo_en; overrun_error SHALL clear only on utrrst or lsr_rd.

Reset
REQ-017 SHALL, on presetn=0, asynchronously clear all pointers, counters and flags; every output SHALL read 0.
REQ-018 SHALL give a clear that coincides with a push precedence, discarding the pushed character.

Configuration
REQ-019 SHALL, with UART_RX_TIMEOUT_EN defined:
- While the FIFO is not empty, count sample_edge pulses.
- Reset the count on a push, on a pop, or when the FIFO is empty.
- Assert rx_timeout when the count reaches TIMEOUT_BITS.
- Deassert rx_timeout on the next pop or clear.
REQ-020 SHALL, without UART_RX_TIMEOUT_EN, tie rx_timeout to 0 and contain no timeout counter logic.

Structure
REQ-021 SHALL take the following from shared package uart_rx_pkg:
- the entry struct type (data, pe, fe, bi);
- trigger-level constants TRIG_1, TRIG_4, TRIG_8, TRIG_14;
- default DEPTH and TIMEOUT_BITS.
REQ-022 SHALL instantiate one sub-module, uart_rx_fifo_mem: a register-array storage with write port and asynchronous read; it SHALL have no reset on the data array.

Verification
REQ-023 Push 0x41, 0x42 and 0x43 with fifo_en=1 and no errors, then pop three times: rbr_data SHALL read 0x41, 0x42, 0x43 in order, the count SHALL go 3->0, and data_ready SHALL be 0 at the end.
REQ-024 Push 17 characters with fifo_en=1 and no pops: the count SHALL be 16, overrun_error SHALL be 1, the 17th character SHALL be lost, and lsr_rd SHALL clear overrun_error.
REQ-025 Push 0x55 with parity_error=1 followed by 0x66 clean: rx_fifo_error SHALL be 1 with head_pe=1; after one pop, rx_fifo_error SHALL be 0 and rbr_data SHALL be 0x66.
REQ-026 With rx_trig=10, push 7 characters then 1 more: rx_trig_hit SHALL be 0 then 1; with the FIFO full, a push and pop in the same cycle SHALL keep the count at 16 with no overrun.
REQ-027 With UART_RX_TIMEOUT_EN, push 1 character and apply 40 sample_edge pulses: rx_timeout SHALL be 1 after the 40th pulse and 0 after the pop; a push at pulse 39 SHALL restart the count.
REQ-028 Assert presetn=0 with 5 entries stored: count, data_ready and overrun_error SHALL be 0 immediately; toggling fifo_en with 3 entries stored SHALL empty the FIFO.
